// File: rtl/alu_iter_if.sv
// Issue-side and writeback-side handshake bundle for alu_iter.
// The slave modport is the ALU. The master modport is its environment.
interface alu_iter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 4
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data_a;
    logic [DATA_WIDTH-1:0] i_data_b;
    logic [INST_WIDTH-1:0] i_inst;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_overflow;

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_inst, i_ready,
        output o_ready, o_valid, o_data, o_overflow
    );

    modport master (
        output i_valid, i_data_a, i_data_b, i_inst, i_ready,
        input  o_ready, o_valid, o_data, o_overflow
    );
endinterface

// File: rtl/alu_iter.sv
// ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish in one cycle. MULU, DIVU and REMU iterate one bit per cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for an operation; accept latches operands and opcode
// S_BUSY | iterative multiply/divide, one step per cycle, counter runs down
// S_DONE | result held on o_data/o_overflow until the consumer takes it
module alu_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    alu_iter_if.slave bus
);
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam int CNT_WIDTH   = $clog2(DATA_WIDTH) + 1;
    localparam int MSB         = DATA_WIDTH - 1;

    localparam logic [INST_WIDTH-1:0] OP_ADD  = INST_WIDTH'(0);
    localparam logic [INST_WIDTH-1:0] OP_SUB  = INST_WIDTH'(1);
    localparam logic [INST_WIDTH-1:0] OP_MULU = INST_WIDTH'(2);
    localparam logic [INST_WIDTH-1:0] OP_DIVU = INST_WIDTH'(3);
    localparam logic [INST_WIDTH-1:0] OP_REMU = INST_WIDTH'(4);
    localparam logic [INST_WIDTH-1:0] OP_AND  = INST_WIDTH'(5);
    localparam logic [INST_WIDTH-1:0] OP_OR   = INST_WIDTH'(6);
    localparam logic [INST_WIDTH-1:0] OP_XOR  = INST_WIDTH'(7);
    localparam logic [INST_WIDTH-1:0] OP_SLL  = INST_WIDTH'(8);
    localparam logic [INST_WIDTH-1:0] OP_SRL  = INST_WIDTH'(9);
    localparam logic [INST_WIDTH-1:0] OP_SRA  = INST_WIDTH'(10);
    localparam logic [INST_WIDTH-1:0] OP_SLT  = INST_WIDTH'(11);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [INST_WIDTH-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    // acc holds the product high half or the partial remainder.
    // lo holds the multiplier/product low half or the dividend/quotient.
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0]  sum, diff, sc_data;
    logic                   sc_ovf, in_iter;
    logic [SHAMT_WIDTH-1:0] shamt;

    logic [DATA_WIDTH-1:0] mul_addend, mul_acc_n, mul_lo_n;
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH-1:0] div_sub, div_acc_n, div_lo_n;
    logic                  div_ge;

    assign bus.o_ready    = (state_q == S_IDLE);
    assign bus.o_valid    = (state_q == S_DONE);
    assign bus.o_data     = data_q;
    assign bus.o_overflow = ovf_q;

    // Single-cycle result from the operands as presented, plus iterative-op detection.
    always_comb begin
        sum     = bus.i_data_a + bus.i_data_b;
        diff    = bus.i_data_a - bus.i_data_b;
        shamt   = bus.i_data_b[SHAMT_WIDTH-1:0];
        sc_data = '0;
        sc_ovf  = 1'b0;
        in_iter = 1'b0;
        case (bus.i_inst)
            OP_ADD: begin
                sc_data = sum;
                sc_ovf  = (bus.i_data_a[MSB] == bus.i_data_b[MSB]) && (sum[MSB] != bus.i_data_a[MSB]);
            end
            OP_SUB: begin
                sc_data = diff;
                sc_ovf  = (bus.i_data_a[MSB] != bus.i_data_b[MSB]) && (diff[MSB] != bus.i_data_a[MSB]);
            end
            OP_MULU, OP_DIVU, OP_REMU: in_iter = 1'b1;
            OP_AND: sc_data = bus.i_data_a & bus.i_data_b;
            OP_OR:  sc_data = bus.i_data_a | bus.i_data_b;
            OP_XOR: sc_data = bus.i_data_a ^ bus.i_data_b;
            OP_SLL: sc_data = bus.i_data_a << shamt;
            OP_SRL: sc_data = bus.i_data_a >> shamt;
            OP_SRA: sc_data = $signed(bus.i_data_a) >>> shamt;
            OP_SLT: sc_data = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.i_data_a) < $signed(bus.i_data_b))};
            default: sc_ovf = 1'b1;
        endcase
    end

    // One shift-add multiply step and one restoring-divide step on the iteration registers.
    always_comb begin
        mul_addend = lo_q[0] ? b_q : '0;
        mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
        mul_acc_n  = mul_sum[DATA_WIDTH:1];
        mul_lo_n   = {mul_sum[0], lo_q[MSB:1]};
        div_shift  = {acc_q, lo_q[MSB]};
        div_ge     = (div_shift >= {1'b0, b_q});
        // The partial remainder stays below 2*B, so the difference fits in DATA_WIDTH bits.
        div_sub    = div_shift[MSB:0] - b_q;
        div_acc_n  = div_ge ? div_sub : div_shift[MSB:0];
        div_lo_n   = {lo_q[MSB-1:0], div_ge};
    end

    // Next-state, iteration and result-register logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        b_d     = b_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    op_d  = bus.i_inst;
                    b_d   = bus.i_data_b;
                    acc_d = '0;
                    lo_d  = bus.i_data_a;
                    if (in_iter) begin
                        cnt_d   = CNT_WIDTH'(DATA_WIDTH);
                        state_d = S_BUSY;
                    end else begin
                        data_d  = sc_data;
                        ovf_d   = sc_ovf;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                acc_d = (op_q == OP_MULU) ? mul_acc_n : div_acc_n;
                lo_d  = (op_q == OP_MULU) ? mul_lo_n  : div_lo_n;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = S_DONE;
                    if (op_q == OP_MULU) begin
                        data_d = mul_lo_n;
                        ovf_d  = (mul_acc_n != '0);
                    end else begin
                        // Divide by zero falls out of the restoring loop as all-ones / A.
                        data_d = (op_q == OP_DIVU) ? div_lo_n : div_acc_n;
                        ovf_d  = (b_q == '0);
                    end
                end
            end
            S_DONE: begin
                if (bus.i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// Directed vector bench for alu_iter: result table plus handshake and reset sequences.
module tb_alu_iter;
    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    alu_iter_if #(.DATA_WIDTH(32), .INST_WIDTH(4)) bus ();

    alu_iter #(.DATA_WIDTH(32), .INST_WIDTH(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge with the ALU expected idle.
    task automatic run_op(input logic [3:0] inst, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic eo, input int el,
                          input string tag, input bit ack);
        int lat;
        chk({tag, " ready before accept"}, {31'd0, bus.o_ready}, 32'd1);
        bus.i_valid  = 1'b1;
        bus.i_inst   = inst;
        bus.i_data_a = a;
        bus.i_data_b = b;
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_inst   = 4'($urandom);
        bus.i_data_a = $urandom;
        bus.i_data_b = $urandom;
        lat = 1;
        while (!bus.o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(el));
        chk({tag, " data"}, bus.o_data, ed);
        chk({tag, " ovf"}, {31'd0, bus.o_overflow}, {31'd0, eo});
        if (ack) begin
            bus.i_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.i_ready = 1'b0;
            chk({tag, " valid drops"}, {31'd0, bus.o_valid}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1});
        vecs.push_back('{4'd0,  32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1});
        vecs.push_back('{4'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1});
        vecs.push_back('{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1});
        vecs.push_back('{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1});
        vecs.push_back('{4'd2,  32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 33});
        vecs.push_back('{4'd2,  32'h00000003, 32'h00000005, 32'h0000000F, 1'b0, 33});
        vecs.push_back('{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 33});
        vecs.push_back('{4'd3,  32'd100,      32'd7,        32'd14,       1'b0, 33});
        vecs.push_back('{4'd4,  32'd100,      32'd7,        32'd2,        1'b0, 33});
        vecs.push_back('{4'd3,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 33});
        vecs.push_back('{4'd4,  32'd5,        32'd0,        32'd5,        1'b1, 33});
        vecs.push_back('{4'd3,  32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 1'b0, 33});
        vecs.push_back('{4'd4,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0, 33});
        vecs.push_back('{4'd3,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 33});
        vecs.push_back('{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1});
        vecs.push_back('{4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1});
        vecs.push_back('{4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1});
        vecs.push_back('{4'd8,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1});
        vecs.push_back('{4'd8,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1});
        vecs.push_back('{4'd10, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1});
        vecs.push_back('{4'd9,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1});
        vecs.push_back('{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1});
        vecs.push_back('{4'd11, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1});
        vecs.push_back('{4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1});
        vecs.push_back('{4'd12, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1});
        vecs.push_back('{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1});

        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_inst   = '0;
        bus.i_data_a = '0;
        bus.i_data_b = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset ready", {31'd0, bus.o_ready}, 32'd1);
        chk("reset valid", {31'd0, bus.o_valid}, 32'd0);
        chk("reset data", bus.o_data, 32'd0);
        chk("reset ovf", {31'd0, bus.o_overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].ovf, vecs[i].lat,
                   $sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: result held for 5 cycles, a pulsed i_valid is dropped.
        run_op(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, "bp add", 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.i_valid  = 1'b1;
                bus.i_inst   = 4'd1;
                bus.i_data_a = 32'd100;
                bus.i_data_b = 32'd1;
            end else begin
                bus.i_valid = 1'b0;
            end
            chk($sformatf("bp valid c%0d", c), {31'd0, bus.o_valid}, 32'd1);
            chk($sformatf("bp ready c%0d", c), {31'd0, bus.o_ready}, 32'd0);
            chk($sformatf("bp data c%0d", c), bus.o_data, 32'd5);
            chk($sformatf("bp ovf c%0d", c), {31'd0, bus.o_overflow}, 32'd0);
            @(posedge clk);
            #1;
        end
        // Hand-off cycle with i_valid high: must not be accepted.
        bus.i_ready  = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_inst   = 4'd7;
        bus.i_data_a = 32'h1;
        bus.i_data_b = 32'h2;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b0;
        chk("handoff valid", {31'd0, bus.o_valid}, 32'd0);
        chk("handoff ready", {31'd0, bus.o_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("handoff no accept", {31'd0, bus.o_valid}, 32'd0);
        run_op(4'd7, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1, "post bp xor", 1'b1);
        run_op(4'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1, 33, "pre rst mulu", 1'b1);

        // Reset in the middle of a divide.
        bus.i_valid  = 1'b1;
        bus.i_inst   = 4'd3;
        bus.i_data_a = 32'd1000;
        bus.i_data_b = 32'd3;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("busy ready low", {31'd0, bus.o_ready}, 32'd0);
        chk("busy valid low", {31'd0, bus.o_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid rst ready", {31'd0, bus.o_ready}, 32'd1);
        chk("mid rst valid", {31'd0, bus.o_valid}, 32'd0);
        chk("mid rst data", bus.o_data, 32'd0);
        chk("mid rst ovf", {31'd0, bus.o_overflow}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after rst valid", {31'd0, bus.o_valid}, 32'd0);
        run_op(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, "after rst add", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
